sobel_filter: RTL and testbench
===============================

Name: sobel_filter

Overview:
- Streaming 3x3 Sobel edge detector for raster-order grayscale frames, one pixel per clock when enabled.
- Two internal line buffers and a 3x3 window produce gradient = |Gx| + |Gy| for every interior pixel.
- Sits between a pixel source (frame memory or sensor stream) and a result sink. Output is an 11-bit magnitude with a one-cycle valid strobe.

Parameters:
- ROW_WIDTH, 64, pixels per row (>=3)
- HEIGHT, 64, rows per frame (>=3)
- DATA_WIDTH, 8, pixel bit width
- THRESHOLD, 128, binarization level (used only with SOBEL_THRESH_EN)

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-low (rst==0 at a rising edge resets)
- recv_data  input  1  pixel-accept enable; pixel is consumed on each rising edge with recv_data==1
- pixel  input  DATA_WIDTH  unsigned pixel, raster order (row-major, col 0 first)
- gradient  output  11  |Gx|+|Gy|, unsigned, max 2040
- gradient_valid  output  1  one-cycle strobe: gradient holds a new result

Behaviour:
- Internal registers row ($clog2(HEIGHT) bits) and col ($clog2(ROW_WIDTH) bits) are named exactly so; benches probe them hierarchically. They give the coordinates of the next pixel to be accepted.
- Accept with col<ROW_WIDTH-1: col+1.
- Accept with col==ROW_WIDTH-1: col=0, row+1.
- Accept at (HEIGHT-1, ROW_WIDTH-1): row=0, col=0, frame complete; the next accept starts a new frame.
- Line buffers: lb_a holds row r-1, lb_b holds row r-2, each ROW_WIDTH x DATA_WIDTH. On accept at column c, the old lb_a[c] moves to lb_b[c] and the pixel is written to lb_a[c].
- Window: three 3-column shift registers (top=r-2, mid=r-1, bot=r). They shift on accept only.
- Window element naming: p[i][j], i = row 0..2 (top..bot), j = col 0..2 (oldest..newest).
- Gx = (p02 + 2p12 + p22) - (p00 + 2p10 + p20)
- Gy = (p20 + 2p21 + p22) - (p00 + 2p01 + p02)
- Compute with signed width >= DATA_WIDTH+4. gradient = |Gx|+|Gy|, zero-extended to 11 bits; no saturation is needed for DATA_WIDTH=8.
- Result window: an accept at (r,c) with r>=2 and c>=2 completes the window centred on (r-1,c-1).
- Latency: gradient and gradient_valid are registered and update on the rising edge after that accept. gradient_valid is high for exactly that one cycle per completed window.
- Results per frame: (HEIGHT-2)*(ROW_WIDTH-2); 3844 at default parameters. Results come out in raster order of centre pixel.
- Border pixels (row 0, last row, col 0, last col) produce no output.
- Window columns left over from the previous row are never used, because of the c>=2 gating.
- recv_data==0 (stall):
  - counters, line buffers and window hold;
  - gradient_valid=0 the next cycle;
  - gradient holds its last value;
  - stalls may occur anywhere, including mid-row and across row boundaries.
- Outputs: gradient holds between strobes; it is never forced to 0 except by reset.
- Reset values: row=0, col=0, gradient=0, gradient_valid=0.
- Line-buffer and window contents are not cleared by reset. Output gating guarantees stale data is never used.
- Reset mid-frame: the next accepted pixel is treated as (0,0) of a new frame.
- Reset has priority over recv_data in the same cycle.

Optional Feature:
- SOBEL_THRESH_EN defined: gradient = 11'h7FF when |Gx|+|Gy| > THRESHOLD, else 0. Valid timing is unchanged.
- SOBEL_THRESH_EN undefined: raw magnitude output as specified above; THRESHOLD is unused.

Test Plan:
- Constant frame (all 0x80), recv_data held high -> exactly 3844 gradient_valid pulses, every gradient=0.
- First valid timing, from reset release with continuous accepts -> first gradient_valid one cycle after the accept at row=2, col=2, i.e. the 131st accepted pixel. Valid deasserts after col=63 of each row and reasserts after col=2 of the next row.
- Vertical edge (cols 0..31 = 0x00, cols 32..63 = 0xFF):
  - centres at col 31 and col 32 -> gradient=0x3FC;
  - all other centres -> 0.
- Horizontal edge (rows 0..31 = 0x00, rows 32..63 = 0xFF) -> centres at rows 31 and 32 give 0x3FC; elsewhere 0.
- Random recv_data stalls (~30% low) with the vertical-edge frame:
  - result stream identical to the unstalled run;
  - gradient_valid never asserts the cycle after a stall cycle.
- Reset pulse mid-frame (rst=0 at row=10), then a full new frame:
  - row/col read 0 after reset;
  - gradient=0 and gradient_valid=0 after reset;
  - 3844 results from the new frame.
- With SOBEL_THRESH_EN, vertical edge, THRESHOLD=128 -> edge results 0x7FF, all others 0.

Source files
------------

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge detector: two line buffers, a 3x3 window, and a
// registered |Gx|+|Gy| output. Define SOBEL_THRESH_EN to binarize against THRESHOLD.
module sobel_filter #(
    parameter int ROW_WIDTH  = 64,
    parameter int HEIGHT     = 64,
    parameter int DATA_WIDTH = 8,
    parameter int THRESHOLD  = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  recv_data,
    input  logic [DATA_WIDTH-1:0] pixel,
    output logic [10:0]           gradient,
    output logic                  gradient_valid
);

    localparam int CW = $clog2(ROW_WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int SW = DATA_WIDTH + 4;

    logic [RW-1:0]         row;
    logic [CW-1:0]         col;
    logic [DATA_WIDTH-1:0] lb_a [ROW_WIDTH];
    logic [DATA_WIDTH-1:0] lb_b [ROW_WIDTH];
    logic [DATA_WIDTH-1:0] win  [3][3];
    logic [DATA_WIDTH-1:0] nxt  [3][3];

    logic                 last_col;
    logic                 last_row;
    logic                 win_done;
    logic signed [SW-1:0] gx;
    logic signed [SW-1:0] gy;
    logic [SW-1:0]        abs_x;
    logic [SW-1:0]        abs_y;
    logic [SW:0]          mag;
    logic [10:0]          result;

    function automatic logic signed [SW-1:0] ext(input logic [DATA_WIDTH-1:0] v);
        return $signed({4'b0000, v});
    endfunction

    assign last_col = (col == CW'(ROW_WIDTH - 1));
    assign last_row = (row == RW'(HEIGHT - 1));
    assign win_done = (row >= RW'(2)) && (col >= CW'(2));

    always_ff @(posedge clk) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (recv_data) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Storage is never cleared; the row/col gating keeps stale contents out of results.
    always_ff @(posedge clk) begin
        if (rst && recv_data) begin
            lb_b[col] <= lb_a[col];
            lb_a[col] <= pixel;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= nxt[i][j];
                end
            end
        end
    end

    // The window as it will look after this accept, so the result registers on the same edge.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            nxt[i][0] = win[i][1];
            nxt[i][1] = win[i][2];
            nxt[i][2] = '0;
        end
        nxt[0][2] = lb_b[col];
        nxt[1][2] = lb_a[col];
        nxt[2][2] = pixel;
    end

    always_comb begin
        gx = (ext(nxt[0][2]) + (ext(nxt[1][2]) <<< 1) + ext(nxt[2][2]))
           - (ext(nxt[0][0]) + (ext(nxt[1][0]) <<< 1) + ext(nxt[2][0]));
        gy = (ext(nxt[2][0]) + (ext(nxt[2][1]) <<< 1) + ext(nxt[2][2]))
           - (ext(nxt[0][0]) + (ext(nxt[0][1]) <<< 1) + ext(nxt[0][2]));
        abs_x = gx[SW-1] ? SW'(-gx) : SW'(gx);
        abs_y = gy[SW-1] ? SW'(-gy) : SW'(gy);
        mag   = {1'b0, abs_x} + {1'b0, abs_y};
`ifdef SOBEL_THRESH_EN
        result = (mag > (SW+1)'(THRESHOLD)) ? 11'h7FF : 11'h000;
`else
        result = (mag > (SW+1)'(2047)) ? 11'h7FF : 11'(mag);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gradient       <= '0;
            gradient_valid <= 1'b0;
        end else begin
            gradient_valid <= recv_data && win_done;
            if (recv_data && win_done) begin
                gradient <= result;
            end
        end
    end

endmodule

// File: tb/tb_sobel_filter.sv
// Self-checking bench for sobel_filter: an image-based reference model feeds a
// scoreboard queue that is drained as gradient_valid strobes appear.
module tb_sobel_filter;

    localparam int W      = 64;
    localparam int H      = 64;
    localparam int THRESH = 128;
`ifdef SOBEL_THRESH_EN
    localparam int EDGE_VAL = 'h7FF;
`else
    localparam int EDGE_VAL = 'h3FC;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        recv_data = 1'b0;
    logic [7:0]  pixel = '0;
    logic [10:0] gradient;
    logic        gradient_valid;

    int tests = 0;
    int fails = 0;
    int img [H][W];
    int exp_q[$];
    int stream_q[$];
    int ref_stream[$];
    int last_grad = 0;

    sobel_filter #(
        .ROW_WIDTH(W), .HEIGHT(H), .DATA_WIDTH(8), .THRESHOLD(THRESH)
    ) dut (
        .clk(clk), .rst(rst), .recv_data(recv_data), .pixel(pixel),
        .gradient(gradient), .gradient_valid(gradient_valid)
    );

    always #5 clk = ~clk;

    // Reference computed straight from the stored image around centre (cr, cc).
    function automatic int sobel_model(input int cr, input int cc);
        int gx, gy, m;
        gx = (img[cr-1][cc+1] + 2*img[cr][cc+1] + img[cr+1][cc+1])
           - (img[cr-1][cc-1] + 2*img[cr][cc-1] + img[cr+1][cc-1]);
        gy = (img[cr+1][cc-1] + 2*img[cr+1][cc] + img[cr+1][cc+1])
           - (img[cr-1][cc-1] + 2*img[cr-1][cc] + img[cr-1][cc+1]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
        m = (m > THRESH) ? 'h7FF : 0;
`endif
        return m;
    endfunction

    task automatic fill_image(input int kind);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (kind)
                    0: img[r][c] = 'h80;
                    1: img[r][c] = (c >= 32) ? 'hFF : 0;
                    2: img[r][c] = (r >= 32) ? 'hFF : 0;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    task automatic drive_frame(input int stall_pct, input int max_pix,
                               output int n_results, output int first_idx);
        int r, c, e;
        logic exp_v;
        n_results = 0;
        first_idx = -1;
        stream_q.delete();
        for (int idx = 0; idx < max_pix; idx++) begin
            r = idx / W;
            c = idx % W;
            for (int s = 0; s < 4; s++) begin
                if (int'($urandom_range(0, 99)) >= stall_pct) break;
                recv_data = 1'b0;
                @(posedge clk); #1;
                tests++;
                if (gradient_valid !== 1'b0 || int'(gradient) !== last_grad) begin
                    fails++;
                    $display("[TB] FAIL stall_hold at (%0d,%0d): valid=%0b grad=%0h, want valid=0 grad=%0h",
                             r, c, gradient_valid, gradient, last_grad);
                end
            end
            recv_data = 1'b1;
            pixel = 8'(img[r][c]);
            exp_v = (r >= 2) && (c >= 2);
            if (exp_v) exp_q.push_back(sobel_model(r - 1, c - 1));
            @(posedge clk); #1;
            tests++;
            if (gradient_valid !== exp_v) begin
                fails++;
                $display("[TB] FAIL valid_timing at (%0d,%0d): got %0b want %0b", r, c, gradient_valid, exp_v);
            end
            if (gradient_valid === 1'b1) begin
                n_results++;
                if (first_idx < 0) first_idx = idx + 1;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL scoreboard_empty at (%0d,%0d): got grad=%0h want none", r, c, gradient);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(gradient) !== e) begin
                        fails++;
                        $display("[TB] FAIL gradient at (%0d,%0d): got %0h want %0h", r, c, gradient, e);
                    end
                end
                stream_q.push_back(int'(gradient));
                last_grad = int'(gradient);
            end else begin
                tests++;
                if (int'(gradient) !== last_grad) begin
                    fails++;
                    $display("[TB] FAIL gradient_hold at (%0d,%0d): got %0h want %0h", r, c, gradient, last_grad);
                end
            end
        end
        recv_data = 1'b0;
    endtask

    task automatic check_frame_done(input string name, input int n, input int first);
        tests++;
        if (n !== (H-2)*(W-2)) begin
            fails++;
            $display("[TB] FAIL %s_count: got %0d want %0d", name, n, (H-2)*(W-2));
        end
        tests++;
        if (first !== 2*W + 3) begin
            fails++;
            $display("[TB] FAIL %s_first_valid: got pixel %0d want %0d", name, first, 2*W + 3);
        end
        tests++;
        if (dut.row !== '0 || dut.col !== '0 || exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s_wrap: got row=%0d col=%0d pending=%0d want 0 0 0",
                     name, dut.row, dut.col, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        recv_data = 1'b1;
        pixel = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (dut.row !== '0 || dut.col !== '0 || gradient !== 11'd0 || gradient_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_state: got row=%0d col=%0d grad=%0h valid=%0b want all 0",
                     dut.row, dut.col, gradient, gradient_valid);
        end
        recv_data = 1'b0;
        rst = 1'b1;
        last_grad = 0;
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_constant_frame();
        int n, first, nonzero;
        fill_image(0);
        drive_frame(0, H*W, n, first);
        check_frame_done("constant", n, first);
        nonzero = 0;
        foreach (stream_q[i]) if (stream_q[i] != 0) nonzero++;
        tests++;
        if (nonzero !== 0) begin
            fails++;
            $display("[TB] FAIL constant_zero: got %0d nonzero results want 0", nonzero);
        end
    endtask

    task automatic test_edge(input int kind, input string name);
        int n, first, n_edge, n_other;
        fill_image(kind);
        drive_frame(0, H*W, n, first);
        check_frame_done(name, n, first);
        n_edge = 0;
        n_other = 0;
        foreach (stream_q[i]) begin
            if (stream_q[i] == EDGE_VAL) n_edge++;
            else if (stream_q[i] != 0) n_other++;
        end
        tests++;
        if (n_edge !== 2*(W-2) || n_other !== 0) begin
            fails++;
            $display("[TB] FAIL %s_pattern: got %0d edge %0d other, want %0d edge 0 other",
                     name, n_edge, n_other, 2*(W-2));
        end
        if (kind == 1) ref_stream = stream_q;
    endtask

    task automatic test_stalls();
        int n, first, diffs;
        fill_image(1);
        drive_frame(30, H*W, n, first);
        tests++;
        if (n !== (H-2)*(W-2) || dut.row !== '0 || dut.col !== '0) begin
            fails++;
            $display("[TB] FAIL stall_count: got %0d results row=%0d col=%0d want %0d 0 0",
                     n, dut.row, dut.col, (H-2)*(W-2));
        end
        diffs = 0;
        for (int i = 0; i < stream_q.size() && i < ref_stream.size(); i++)
            if (stream_q[i] != ref_stream[i]) diffs++;
        tests++;
        if (diffs !== 0 || stream_q.size() != ref_stream.size()) begin
            fails++;
            $display("[TB] FAIL stall_stream: got %0d diffs size %0d want 0 diffs size %0d",
                     diffs, stream_q.size(), ref_stream.size());
        end
    endtask

    task automatic test_mid_reset();
        int n, first;
        fill_image(3);
        drive_frame(0, 10*W + 5, n, first);
        rst = 1'b0;
        recv_data = 1'b1;
        pixel = 8'h55;
        @(posedge clk); #1;
        tests++;
        if (dut.row !== '0 || dut.col !== '0 || gradient !== 11'd0 || gradient_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_reset_state: got row=%0d col=%0d grad=%0h valid=%0b want all 0",
                     dut.row, dut.col, gradient, gradient_valid);
        end
        rst = 1'b1;
        recv_data = 1'b0;
        last_grad = 0;
        exp_q.delete();
        fill_image(3);
        drive_frame(0, H*W, n, first);
        check_frame_done("after_reset", n, first);
    endtask

    initial begin
        test_reset();
        test_constant_frame();
        test_edge(1, "vertical");
        test_edge(2, "horizontal");
        test_stalls();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL timeout: simulation did not finish within 5ms");
        $fatal(1, "[TB] timeout");
    end

endmodule
